// File: rtl/ic_7474_pkg.sv
// ic_7474_pkg
// Shared constants for the dual D flip-flop block:
//   - reset values of the output registers and of the previous-CP register
//   - inactive (idle) pin values loaded into the input synchronizers on reset
//   - the legal values of the SYNC_STAGES parameter
//   - pins_t, the packed bundle of one channel's pin inputs
package ic_7474_pkg;

    localparam logic Q_RST       = 1'b0;
    localparam logic NQ_RST      = 1'b1;
    localparam logic CP_PREV_RST = 1'b1;

    // Inactive pin values seen by the synchronizers after reset.
    localparam logic SD_RST = 1'b1;
    localparam logic RD_RST = 1'b1;
    localparam logic D_RST  = 1'b0;

    // Legal synchronizer depths.
    localparam int SYNC_STAGES_NONE  = 0;
    localparam int SYNC_STAGES_TWO   = 2;
    localparam int SYNC_STAGES_THREE = 3;

    typedef struct packed {
        logic cp;
        logic d;
        logic sd;
        logic rd;
    } pins_t;

    // CP resets high, like the previous-CP register, so that a CP pin held
    // high through reset release never looks like a rising edge.
    localparam pins_t PINS_RST = '{cp: CP_PREV_RST, d: D_RST, sd: SD_RST, rd: RD_RST};

endpackage

// File: rtl/ic_7474_ff.sv
// ic_7474_ff
// One channel of the dual D flip-flop: optional input synchronizer,
// CP rising-edge detection, set/clear/capture priority and the registered
// Q / nQ outputs.  Everything is clocked by clk.
// Ports:
//   clk, rst        : system clock, synchronous active-high reset
//   cp, d, sd, rd   : pin inputs (sd and rd active-low)
//   q, nq           : registered true and complement outputs
module ic_7474_ff
    import ic_7474_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_NONE
) (
    input  logic clk,
    input  logic rst,
    input  logic cp,
    input  logic d,
    input  logic sd,
    input  logic rd,
    output logic q,
    output logic nq
);

    pins_t pins_raw;
    pins_t pins_s;

    assign pins_raw = '{cp: cp, d: d, sd: sd, rd: rd};

    // All four pins travel through the same chain so D stays aligned with
    // the CP sample it is captured with.
    generate
        if (SYNC_STAGES == SYNC_STAGES_NONE) begin : g_nosync
            assign pins_s = pins_raw;
        end else begin : g_sync
            pins_t stage [SYNC_STAGES];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < SYNC_STAGES; i++) begin
                        stage[i] <= PINS_RST;
                    end
                end else begin
                    stage[0] <= pins_raw;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign pins_s = stage[SYNC_STAGES-1];
        end
    endgenerate

    logic cp_prev;
    logic cp_rise;
    logic q_next;
    logic nq_next;

    assign cp_rise = pins_s.cp & ~cp_prev;

    // The hold case drives nq from ~q rather than from nq so that leaving
    // the both-asserted state (q=1, nq=1) settles to nq=0 on the next edge.
    // An edge arriving while set or clear is asserted is simply dropped.
    always_comb begin
        q_next  = q;
        nq_next = ~q;
        case ({pins_s.sd, pins_s.rd})
            2'b00: begin
                q_next  = 1'b1;
                nq_next = 1'b1;
            end
            2'b01: begin
                q_next  = 1'b1;
                nq_next = 1'b0;
            end
            2'b10: begin
                q_next  = 1'b0;
                nq_next = 1'b1;
            end
            default: begin
                if (cp_rise) begin
                    q_next  = pins_s.d;
                    nq_next = ~pins_s.d;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q       <= Q_RST;
            nq      <= NQ_RST;
            cp_prev <= CP_PREV_RST;
        end else begin
            q       <= q_next;
            nq      <= nq_next;
            cp_prev <= pins_s.cp;
        end
    end

endmodule

// File: rtl/ic_7474.sv
// ic_7474
// Dual positive-edge D flip-flop with active-low preset and clear, rebuilt
// as a single-clock synchronous block.  The CP pins are data inputs sampled
// by clk; a low-to-high CP transition acts as the flop's clock edge.
// Ports:
//   Q1, nQ1, Q2, nQ2     : registered outputs of channel 1 / channel 2
//   CP1, D1, SD1, RD1    : channel 1 clock, data, preset (low), clear (low)
//   CP2, D2, SD2, RD2    : channel 2 clock, data, preset (low), clear (low)
//   clk                  : system clock
//   rst                  : synchronous active-high reset
// SYNC_STAGES selects 0, 2 or 3 synchronizer flops on every pin input; the
// pin-to-output latency is SYNC_STAGES+1 clk cycles.
module ic_7474
    import ic_7474_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_NONE
) (
    output logic Q1,
    output logic nQ1,
    input  logic CP1,
    input  logic D1,
    input  logic SD1,
    input  logic RD1,
    output logic Q2,
    output logic nQ2,
    input  logic CP2,
    input  logic D2,
    input  logic SD2,
    input  logic RD2,
    input  logic clk,
    input  logic rst
);

    ic_7474_ff #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_ff1 (
        .clk (clk),
        .rst (rst),
        .cp  (CP1),
        .d   (D1),
        .sd  (SD1),
        .rd  (RD1),
        .q   (Q1),
        .nq  (nQ1)
    );

    ic_7474_ff #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_ff2 (
        .clk (clk),
        .rst (rst),
        .cp  (CP2),
        .d   (D2),
        .sd  (SD2),
        .rd  (RD2),
        .q   (Q2),
        .nq  (nQ2)
    );

endmodule

// File: tb/tb_ic_7474.sv
// tb_ic_7474
// Directed steps followed by a randomized phase, all checked every cycle
// against a behavioural model of the dual flip-flop, plus spot checks of
// fixed expected values at the interesting points.
module tb_ic_7474;

    localparam int SYNC = 2;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // pin bundles: index 0 is channel 1, index 1 is channel 2
    logic [1:0] cp = 2'b00;
    logic [1:0] d  = 2'b00;
    logic [1:0] sd = 2'b11;
    logic [1:0] rd = 2'b11;

    logic Q1, nQ1, Q2, nQ2;

    ic_7474 #(
        .SYNC_STAGES(SYNC)
    ) dut (
        .Q1  (Q1),
        .nQ1 (nQ1),
        .CP1 (cp[0]),
        .D1  (d[0]),
        .SD1 (sd[0]),
        .RD1 (rd[0]),
        .Q2  (Q2),
        .nQ2 (nQ2),
        .CP2 (cp[1]),
        .D2  (d[1]),
        .SD2 (sd[1]),
        .RD2 (rd[1]),
        .clk (clk),
        .rst (rst)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model.  Pins reach the decision logic SYNC cycles late, so
    // the model keeps a delay line of pin snapshots {ch2[3:0], ch1[3:0]},
    // each nibble being {cp, d, sd, rd}.
    logic [7:0] hist[$];
    logic [1:0] m_q;
    logic [1:0] m_nq;
    logic [1:0] m_prev;

    task automatic model_edge();
        logic [7:0] cur;
        logic [7:0] used;
        logic [3:0] p;
        cur = {cp[1], d[1], sd[1], rd[1], cp[0], d[0], sd[0], rd[0]};
        if (rst) begin
            hist.delete();
            repeat (SYNC) hist.push_back(8'b1011_1011);
            m_q    = 2'b00;
            m_nq   = 2'b11;
            m_prev = 2'b11;
        end else begin
            hist.push_back(cur);
            used = hist.pop_front();
            for (int ch = 0; ch < 2; ch++) begin
                p = used[ch*4 +: 4];
                // p = {cp, d, sd, rd}
                if (!p[1] && !p[0]) begin
                    m_q[ch] = 1'b1;  m_nq[ch] = 1'b1;
                end else if (!p[1]) begin
                    m_q[ch] = 1'b1;  m_nq[ch] = 1'b0;
                end else if (!p[0]) begin
                    m_q[ch] = 1'b0;  m_nq[ch] = 1'b1;
                end else if (p[3] && !m_prev[ch]) begin
                    m_q[ch] = p[2];  m_nq[ch] = ~p[2];
                end else begin
                    m_nq[ch] = ~m_q[ch];
                end
                m_prev[ch] = p[3];
            end
        end
    endtask

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: update the model at the edge, then compare #1 later.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check("model_q",  {Q2, Q1},   m_q);
        check("model_nq", {nQ2, nQ1}, m_nq);
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    int lat;

    initial begin
        // Reset with arbitrary pins.
        rst = 1'b1;
        cp = 2'($urandom); d = 2'($urandom); sd = 2'($urandom); rd = 2'($urandom);
        run(1);
        // Last reset cycle: CP high, D high, pins idle.
        cp = 2'b11; d = 2'b11; sd = 2'b11; rd = 2'b11;
        run(1);
        check("reset_q",  {Q2, Q1},   2'b00);
        check("reset_nq", {nQ2, nQ1}, 2'b11);
        rst = 1'b0;

        // CP held high through release: no capture.
        run(5);
        check("cp_high_no_capture_q", {Q2, Q1}, 2'b00);

        // Capture D=1 then D=0.
        cp = 2'b00; run(3);
        cp = 2'b11; run(3);
        check("capture1_q",  {Q2, Q1},   2'b11);
        check("capture1_nq", {nQ2, nQ1}, 2'b00);
        d = 2'b00; cp = 2'b00; run(3);
        cp = 2'b11; run(3);
        check("capture0_q", {Q2, Q1}, 2'b00);

        // Clear asserted while CP toggles with D=1.
        rd = 2'b00; d = 2'b11;
        for (int i = 0; i < 4; i++) begin
            cp = 2'b00; run(2);
            cp = 2'b11; run(2);
        end
        run(3);
        check("clear_q",  {Q2, Q1},   2'b00);
        check("clear_nq", {nQ2, nQ1}, 2'b11);
        cp = 2'b00; rd = 2'b11; run(4);
        check("clear_no_deferred_q", {Q2, Q1}, 2'b00);
        cp = 2'b11; run(3);
        check("after_clear_capture_q", {Q2, Q1}, 2'b11);

        // Both asserted, release clear first, then preset.
        d = 2'b00; cp = 2'b00;
        rd = 2'b00; run(4);
        sd = 2'b00; run(4);
        check("both_q",  {Q2, Q1},   2'b11);
        check("both_nq", {nQ2, nQ1}, 2'b11);
        rd = 2'b11; run(4);
        check("preset_only_q",  {Q2, Q1},   2'b11);
        check("preset_only_nq", {nQ2, nQ1}, 2'b00);
        sd = 2'b11; run(4);
        check("release_hold_nq", {nQ2, nQ1}, 2'b00);
        cp = 2'b11; run(3);
        check("resume_capture_q", {Q2, Q1}, 2'b00);

        // Independence: channel 1 clocks, channel 2 stays put; then swap.
        cp = 2'b00; run(3);
        d = 2'b11;
        cp[0] = 1'b1; run(3);
        check("indep_ch1_q", {Q2, Q1}, 2'b01);
        cp[0] = 1'b0; run(2);
        d = 2'b10;
        cp[1] = 1'b1; run(3);
        check("indep_ch2_q", {Q2, Q1}, 2'b11);
        cp[1] = 1'b0; run(2);

        // Latency: SD1 falls -> Q1 rises exactly SYNC+1 cycles later.
        rd[0] = 1'b0; run(4);
        rd[0] = 1'b1; run(4);
        check("latency_pre_q1", {1'b0, Q1}, 2'b00);
        sd[0] = 1'b0;
        lat = 0;
        while (lat < 10) begin
            cycle();
            lat++;
            if (Q1 === 1'b1) break;
        end
        check_int("sd_latency_cycles", lat, SYNC + 1);
        sd[0] = 1'b1; run(4);

        // Randomized phase with occasional resets.
        for (int i = 0; i < 400; i++) begin
            cp  = 2'($urandom);
            d   = 2'($urandom);
            sd  = {($urandom_range(0, 5) != 0), ($urandom_range(0, 5) != 0)};
            rd  = {($urandom_range(0, 5) != 0), ($urandom_range(0, 5) != 0)};
            rst = ($urandom_range(0, 60) == 0);
            cycle();
        end
        rst = 1'b0;
        run(4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ic_7474.md
IC_7474 -- requirements
Module: ic_7474

Interface
REQ-001 Parameter: SYNC_STAGES, default 0, number of input synchronizer flops on every pin input (legal values 0, 2 and 3).
REQ-002 clk  input  1  the one clock; all state changes SHALL occur on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 CP1, CP2  input  1 each  per-flop data clock pin, sampled by clk; a low-to-high transition is an active edge.
REQ-005 D1, D2  input  1 each  per-flop data pin.
REQ-006 SD1, SD2  input  1 each  per-flop set (preset) pin, active-low.
REQ-007 RD1, RD2  input  1 each  per-flop clear pin, active-low.
REQ-008 Q1, Q2  output  1 each  true output of each flop, registered.
REQ-009 nQ1, nQ2  output  1 each  complement output of each flop, registered.
REQ-010 Port declaration order SHALL be: Q1, nQ1, CP1, D1, SD1, RD1, Q2, nQ2, CP2, D2, SD2, RD2, clk, rst.

Function
REQ-011 The block SHALL contain two identical, fully independent flop channels; no pin of one channel SHALL affect the other.
REQ-012 Each channel SHALL apply the following priority every clk rising edge, evaluated on the synchronized pin values:
- SD=0, RD=0: Q=1, nQ=1.
- SD=0, RD=1: Q=1, nQ=0.
- SD=1, RD=0: Q=0, nQ=1.
- SD=1, RD=1 with a CP active edge: Q=D, nQ=~D.
- SD=1, RD=1 without an edge: Q and nQ hold.
REQ-013 An active CP edge SHALL be detected when the registered previous CP sample is 0 and the current sample is 1; the D value used SHALL be the one sampled in the same clk cycle as the CP=1 sample.
REQ-014 A CP edge coinciding with SD=0 or RD=0 SHALL be ignored; it SHALL NOT be deferred.
REQ-015 On leaving the SD=0,RD=0 state directly to SD=1,RD=1, Q SHALL hold 1 and nQ SHALL become 0 on the next clk edge.
REQ-016 On leaving SD=0,RD=0 to a single asserted pin, REQ-012 SHALL apply.
REQ-017 Latency from a pin change to the output change SHALL be SYNC_STAGES+1 clk cycles.
REQ-018 A CP held high SHALL produce exactly one capture; CP falling edges SHALL have no effect.
REQ-019 Outside the SD=0,RD=0 state, nQ SHALL always equal ~Q.

Reset
REQ-020 While rst=1 at a clk edge, each channel SHALL set Q=0 and nQ=1, clear all synchronizer stages to the inactive pin values (SD=1, RD=1, D=0), and set the previous-CP register to 1.
REQ-021 Setting the previous-CP register to 1 SHALL ensure that a CP held high through reset release does not produce a capture.
REQ-022 rst SHALL take priority over every pin input.
REQ-023 rst asserted mid-operation SHALL take effect at the next clk edge.

Structure
REQ-024 A package ic_7474_pkg SHALL hold the reset constants (Q_RST=0, NQ_RST=1, CP_PREV_RST=1) and the legal SYNC_STAGES values.
REQ-025 One sub-module, ic_7474_ff, SHALL implement a single channel (synchronizer, edge detect, priority logic and output registers).
REQ-026 ic_7474_ff SHALL be instantiated twice in ic_7474.

Verification
REQ-027 Reset: apply rst=1 for 2 cycles with all pins arbitrary -> Q1=Q2=0 and nQ1=nQ2=1 after release.
REQ-028 Capture: SD=RD=11, D=11, toggle CP -> Q=11 and nQ=00 one cycle after the CP rise; then D=00 -> Q=00 after the next CP rise.
REQ-029 Clear: RD=00, SD=11, D=11 while toggling CP -> Q=00, nQ=11 with no captures; restoring RD=11 -> Q follows D at the next CP rise.
REQ-030 Both asserted: RD=00 then SD=00 -> Q=11, nQ=11; release RD first -> Q=11, nQ=00; release SD -> normal capture resumes.
REQ-031 Independence: CP1 toggling with D1=1 while CP2 is held at 0 -> Q1=1 and Q2 unchanged; repeat with channels swapped.
REQ-032 Edge/latency: CP held high through reset release -> no capture; with SYNC_STAGES=2, an SD1 fall -> Q1=1 exactly 3 cycles later.
